uart_cmd_ctrl: RTL and testbench

Register-access command controller that sequences the `uart` block. It parses received byte frames into register write/read transactions on a simple register port. It then drives the UART transmitter to return an acknowledge byte or the read data. It sits between the `uart` instance and the design's configuration register file.

---
 rtl/uart_cmd_pkg.sv | 18 +
 rtl/uart_byte_timer.sv | 42 ++++
 rtl/uart_cmd_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART register-access command controller.
package uart_cmd_pkg;

    localparam int unsigned CMD_WR_BIT       = 7;
    localparam logic [7:0]  DEFAULT_ACK_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RX_DATA  = 3'd1,
        ST_WRITE    = 3'd2,
        ST_READ_REQ = 3'd3,
        ST_READ_CAP = 3'd4,
        ST_TX_LOAD  = 3'd5,
        ST_TX_GUARD = 3'd6,
        ST_TX_WAIT  = 3'd7
    } state_e;

endpackage

// File: rtl/uart_byte_timer.sv
// Inter-byte timeout counter: cleared by clr, counts while en, saturates at the limit.
module uart_byte_timer
    import uart_cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 20000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] count_q, count_d;
    logic             expired_q, expired_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != LIMIT)) begin
            count_d = count_q + CNT_W'(1);
        end
        expired_d = (count_d == LIMIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= '0;
            expired_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            expired_q <= expired_d;
        end
    end

    assign expired = expired_q;

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Parses UART command frames into register reads/writes and returns an ACK or the
// read data through the UART transmitter.
module uart_cmd_ctrl
    import uart_cmd_pkg::*;
#(
    parameter int unsigned ADDR_W         = 7,
    parameter int unsigned DATA_BYTES     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 20000,
    parameter logic [7:0]  ACK_BYTE       = DEFAULT_ACK_BYTE
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    uart_received,
    input  logic [7:0]              uart_rx_byte,
    input  logic                    uart_recv_error,
    input  logic                    uart_is_transmitting,
    output logic                    uart_transmit,
    output logic [7:0]              uart_tx_byte,
    output logic                    reg_we,
    output logic                    reg_re,
    output logic [ADDR_W-1:0]       reg_addr,
    output logic [8*DATA_BYTES-1:0] reg_wdata,
    input  logic [8*DATA_BYTES-1:0] reg_rdata,
    output logic                    busy,
    output logic                    frame_err
);

    localparam int unsigned DW    = 8 * DATA_BYTES;
    localparam int unsigned IDX_W = $clog2(DATA_BYTES + 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]      shift_q, shift_d;
    logic [ADDR_W-1:0]  reg_addr_q, reg_addr_d;
    logic [DW-1:0]      reg_wdata_q, reg_wdata_d;
    logic [7:0]         tx_byte_q, tx_byte_d;
    logic               transmit_q, transmit_d;
    logic               reg_we_q, reg_we_d;
    logic               reg_re_q, reg_re_d;
    logic               busy_q, busy_d;
    logic               frame_err_q, frame_err_d;
    logic               expired;
    logic               last_byte;

    uart_byte_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (uart_received),
        .en      (state_q == ST_RX_DATA),
        .expired (expired)
    );

    assign last_byte = (idx_q == IDX_W'(DATA_BYTES - 1));

    // State register and datapath flops
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            shift_q     <= '0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            tx_byte_q   <= '0;
            transmit_q  <= 1'b0;
            reg_we_q    <= 1'b0;
            reg_re_q    <= 1'b0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            tx_byte_q   <= tx_byte_d;
            transmit_q  <= transmit_d;
            reg_we_q    <= reg_we_d;
            reg_re_q    <= reg_re_d;
            busy_q      <= busy_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Next-state logic; a byte arriving in RX_DATA takes priority over the timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (uart_received) begin
                    state_d = uart_rx_byte[CMD_WR_BIT] ? ST_RX_DATA : ST_READ_REQ;
                end
            end
            ST_RX_DATA: begin
                if (uart_recv_error) begin
                    state_d = ST_IDLE;
                end else if (uart_received) begin
                    if (last_byte) begin
                        state_d = ST_WRITE;
                    end
                end else if (expired) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE:    state_d = ST_TX_LOAD;
            ST_READ_REQ: state_d = ST_READ_CAP;
            ST_READ_CAP: state_d = ST_TX_LOAD;
            ST_TX_LOAD: begin
                if (!uart_is_transmitting) begin
                    state_d = ST_TX_GUARD;
                end
            end
            ST_TX_GUARD: state_d = ST_TX_WAIT;
            ST_TX_WAIT: begin
                if (!uart_is_transmitting) begin
                    state_d = (cnt_q != '0) ? ST_TX_LOAD : ST_IDLE;
                end
            end
            default:     state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next values; all outputs leave through flops
    always_comb begin
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        tx_byte_d   = tx_byte_q;
        transmit_d  = 1'b0;
        reg_we_d    = 1'b0;
        reg_re_d    = 1'b0;
        frame_err_d = 1'b0;
        busy_d      = (state_d != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (uart_received) begin
                    reg_addr_d = uart_rx_byte[ADDR_W-1:0];
                    idx_d      = '0;
                end
            end
            ST_RX_DATA: begin
                if (uart_recv_error) begin
                    frame_err_d = 1'b1;
                end else if (uart_received) begin
                    reg_wdata_d[8*int'(idx_q) +: 8] = uart_rx_byte;
                    idx_d = idx_q + IDX_W'(1);
                end else if (expired) begin
                    frame_err_d = 1'b1;
                end
            end
            ST_WRITE: begin
                reg_we_d = 1'b1;
                shift_d  = DW'(ACK_BYTE);
                cnt_d    = IDX_W'(1);
            end
            ST_READ_REQ: begin
                reg_re_d = 1'b1;
            end
            ST_READ_CAP: begin
                shift_d = reg_rdata;
                cnt_d   = IDX_W'(DATA_BYTES);
            end
            ST_TX_LOAD: begin
                if (!uart_is_transmitting) begin
                    transmit_d = 1'b1;
                    tx_byte_d  = shift_q[7:0];
                end
            end
            ST_TX_GUARD: begin
                shift_d = shift_q >> 8;
                cnt_d   = cnt_q - IDX_W'(1);
            end
            default: ;
        endcase
        // Bytes arriving mid-transaction are dropped and flagged
        if (uart_received && (state_q != ST_IDLE) && (state_q != ST_RX_DATA)) begin
            frame_err_d = 1'b1;
        end
    end

    assign uart_transmit = transmit_q;
    assign uart_tx_byte  = tx_byte_q;
    assign reg_we        = reg_we_q;
    assign reg_re        = reg_re_q;
    assign reg_addr      = reg_addr_q;
    assign reg_wdata     = reg_wdata_q;
    assign busy          = busy_q;
    assign frame_err     = frame_err_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Scoreboard bench for uart_cmd_ctrl: expected register/UART events are queued in
// order and checked as the DUT produces them.
module tb_uart_cmd_ctrl;

    localparam int unsigned T_OUT     = 40;
    localparam int unsigned UART_BUSY = 10;
    localparam int          K_WE = 0, K_RE = 1, K_TX = 2;

    typedef struct {
        int          kind;
        logic [6:0]  addr;
        logic [15:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        uart_received = 1'b0;
    logic [7:0]  uart_rx_byte = 8'h00;
    logic        uart_recv_error = 1'b0;
    logic        uart_is_transmitting;
    logic        uart_transmit;
    logic [7:0]  uart_tx_byte;
    logic        reg_we, reg_re;
    logic [6:0]  reg_addr;
    logic [15:0] reg_wdata;
    logic [15:0] reg_rdata = 16'h0000;
    logic        busy, frame_err;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   tx_seen  = 0;
    int   ubusy    = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    uart_cmd_ctrl #(
        .ADDR_W         (7),
        .DATA_BYTES     (2),
        .TIMEOUT_CYCLES (T_OUT),
        .ACK_BYTE       (8'hA5)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .uart_received        (uart_received),
        .uart_rx_byte         (uart_rx_byte),
        .uart_recv_error      (uart_recv_error),
        .uart_is_transmitting (uart_is_transmitting),
        .uart_transmit        (uart_transmit),
        .uart_tx_byte         (uart_tx_byte),
        .reg_we               (reg_we),
        .reg_re               (reg_re),
        .reg_addr             (reg_addr),
        .reg_wdata            (reg_wdata),
        .reg_rdata            (reg_rdata),
        .busy                 (busy),
        .frame_err            (frame_err)
    );

    always #5 clk = ~clk;

    // UART transmitter stand-in: busy for UART_BUSY cycles after each request
    always @(posedge clk) begin
        if (uart_transmit) ubusy <= UART_BUSY;
        else if (ubusy != 0) ubusy <= ubusy - 1;
    end
    assign uart_is_transmitting = (ubusy != 0);

    // Scoreboard: each DUT strobe must match the next expected event in order
    always @(negedge clk) begin
        if (reg_we) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++; $display("FAIL we_unexpected: got addr=%h wdata=%h, required no write", reg_addr, reg_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.kind != K_WE || reg_addr !== mon_e.addr || reg_wdata !== mon_e.data) begin
                    n_fail++; $display("FAIL we_event: got we addr=%h wdata=%h, required kind=%0d addr=%h data=%h", reg_addr, reg_wdata, mon_e.kind, mon_e.addr, mon_e.data);
                end
            end
        end
        if (reg_re) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++; $display("FAIL re_unexpected: got addr=%h, required no read", reg_addr);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.kind != K_RE || reg_addr !== mon_e.addr) begin
                    n_fail++; $display("FAIL re_event: got re addr=%h, required kind=%0d addr=%h", reg_addr, mon_e.kind, mon_e.addr);
                end
            end
        end
        if (uart_transmit) begin
            tx_seen++;
            n_checks++;
            if (uart_is_transmitting !== 1'b0) begin
                n_fail++; $display("FAIL tx_overlap: got uart_is_transmitting=%b at transmit, required 0", uart_is_transmitting);
            end
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++; $display("FAIL tx_unexpected: got byte=%h, required no transmit", uart_tx_byte);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.kind != K_TX || uart_tx_byte !== mon_e.data[7:0]) begin
                    n_fail++; $display("FAIL tx_event: got tx byte=%h, required kind=%0d byte=%h", uart_tx_byte, mon_e.kind, mon_e.data[7:0]);
                end
            end
        end
    end

    function automatic exp_t mk(input int kind, input logic [6:0] addr, input logic [15:0] data);
        exp_t e;
        e.kind = kind; e.addr = addr; e.data = data;
        return e;
    endfunction

    // Called at a negedge; returns at the next negedge with the strobe dropped
    task automatic send_byte(input logic [7:0] b);
        uart_rx_byte  = b;
        uart_received = 1'b1;
        @(negedge clk);
        uart_received = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit done = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!busy && !uart_is_transmitting) begin done = 1; break; end
        end
        n_checks++;
        if (!done) begin n_fail++; $display("FAIL %s_idle: got busy=%b after 300 cycles, required 0", name, busy); end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL %s_pending: got %0d expected events outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic wait_tx(input string name);
        bit done = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (uart_transmit) begin done = 1; break; end
        end
        n_checks++;
        if (!done) begin n_fail++; $display("FAIL %s_tx_wait: got no transmit in 100 cycles, required one", name); end
    endtask

    task automatic check_all_zero(input string name);
        n_checks++;
        if ({uart_transmit, uart_tx_byte, reg_we, reg_re, reg_addr, reg_wdata, busy, frame_err} !== '0) begin
            n_fail++;
            $display("FAIL %s_outputs: got tx=%b txb=%h we=%b re=%b addr=%h wdata=%h busy=%b ferr=%b, required all 0",
                     name, uart_transmit, uart_tx_byte, reg_we, reg_re, reg_addr, reg_wdata, busy, frame_err);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("post_reset");
    endtask

    task automatic test_write();
        exp_q.push_back(mk(K_WE, 7'h05, 16'h1234));
        exp_q.push_back(mk(K_TX, 7'h00, 16'h00A5));
        send_byte(8'h85);
        send_byte(8'h34);
        send_byte(8'h12);
        @(negedge clk);
        n_checks++;
        if (reg_we !== 1'b1) begin n_fail++; $display("FAIL write_we_timing: got reg_we=%b 2 cycles after last byte, required 1", reg_we); end
        @(negedge clk);
        n_checks++;
        if (uart_transmit !== 1'b1) begin n_fail++; $display("FAIL write_ack_timing: got uart_transmit=%b 1 cycle after reg_we, required 1", uart_transmit); end
        wait_idle("write");
    endtask

    task automatic test_read();
        reg_rdata = 16'hBEEF;
        exp_q.push_back(mk(K_RE, 7'h05, 16'h0000));
        exp_q.push_back(mk(K_TX, 7'h00, 16'h00EF));
        exp_q.push_back(mk(K_TX, 7'h00, 16'h00BE));
        send_byte(8'h05);
        @(negedge clk);
        n_checks++;
        if (reg_re !== 1'b1) begin n_fail++; $display("FAIL read_re_timing: got reg_re=%b 2 cycles after command, required 1", reg_re); end
        wait_idle("read");
    endtask

    task automatic test_timeout();
        int  gap = -1;
        int  errs_seen = 0;
        send_byte(8'h85);
        send_byte(8'h34);
        for (int i = 1; i <= int'(T_OUT) + 20; i++) begin
            @(negedge clk);
            if (frame_err) begin gap = i; break; end
        end
        n_checks++;
        if (gap < int'(T_OUT) || gap > int'(T_OUT) + 2) begin
            n_fail++; $display("FAIL timeout_window: got frame_err after %0d cycles, required %0d..%0d", gap, T_OUT, T_OUT + 2);
        end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL timeout_idle: got busy=%b, required 0", busy); end
        @(negedge clk);
        n_checks++;
        if (frame_err !== 1'b0) begin n_fail++; $display("FAIL timeout_pulse: got frame_err=%b next cycle, required 0", frame_err); end
        // Recovery write
        exp_q.push_back(mk(K_WE, 7'h01, 16'h0001));
        exp_q.push_back(mk(K_TX, 7'h00, 16'h00A5));
        send_byte(8'h81);
        send_byte(8'h01);
        send_byte(8'h00);
        wait_idle("timeout_recover");
        // A byte landing on the expiry cycle wins over the timeout
        exp_q.push_back(mk(K_WE, 7'h05, 16'h2211));
        exp_q.push_back(mk(K_TX, 7'h00, 16'h00A5));
        send_byte(8'h85);
        repeat (T_OUT) @(negedge clk);
        send_byte(8'h11);
        if (frame_err) errs_seen++;
        send_byte(8'h22);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (frame_err) errs_seen++;
        end
        n_checks++;
        if (errs_seen != 0) begin n_fail++; $display("FAIL timeout_tie: got %0d frame_err pulses, required 0", errs_seen); end
        wait_idle("timeout_tie");
    endtask

    task automatic test_recv_error();
        send_byte(8'h85);
        uart_recv_error = 1'b1;
        @(negedge clk);
        uart_recv_error = 1'b0;
        n_checks++;
        if (frame_err !== 1'b1) begin n_fail++; $display("FAIL recv_err_pulse: got frame_err=%b, required 1", frame_err); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL recv_err_idle: got busy=%b, required 0", busy); end
        repeat (5) @(negedge clk);
        wait_idle("recv_err");
    endtask

    task automatic test_rx_during_resp();
        reg_rdata = 16'h5AC3;
        exp_q.push_back(mk(K_RE, 7'h0A, 16'h0000));
        exp_q.push_back(mk(K_TX, 7'h00, 16'h00C3));
        exp_q.push_back(mk(K_TX, 7'h00, 16'h005A));
        send_byte(8'h0A);
        wait_tx("rx_resp");
        repeat (2) @(negedge clk);
        send_byte(8'h77);
        n_checks++;
        if (frame_err !== 1'b1) begin n_fail++; $display("FAIL rx_resp_err: got frame_err=%b, required 1", frame_err); end
        wait_idle("rx_resp");
    endtask

    task automatic test_reset_mid();
        int tx_before;
        reg_rdata = 16'h1357;
        exp_q.push_back(mk(K_RE, 7'h03, 16'h0000));
        exp_q.push_back(mk(K_TX, 7'h00, 16'h0057));
        send_byte(8'h03);
        wait_tx("rst_mid");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_all_zero("rst_mid");
        tx_before = tx_seen;
        repeat (40) @(negedge clk);
        n_checks++;
        if (tx_seen != tx_before) begin n_fail++; $display("FAIL rst_mid_drop: got %0d transmits after reset, required 0", tx_seen - tx_before); end
        wait_idle("rst_mid");
    endtask

    task automatic test_back_to_back();
        reg_rdata = 16'h4321;
        exp_q.push_back(mk(K_WE, 7'h02, 16'hABCD));
        exp_q.push_back(mk(K_TX, 7'h00, 16'h00A5));
        exp_q.push_back(mk(K_RE, 7'h02, 16'h0000));
        exp_q.push_back(mk(K_TX, 7'h00, 16'h0021));
        exp_q.push_back(mk(K_TX, 7'h00, 16'h0043));
        send_byte(8'h82);
        send_byte(8'hCD);
        send_byte(8'hAB);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        send_byte(8'h02);
        wait_idle("b2b");
        n_checks++;
        if (reg_addr !== 7'h02 || reg_wdata !== 16'hABCD) begin
            n_fail++; $display("FAIL b2b_hold: got addr=%h wdata=%h, required 02/abcd", reg_addr, reg_wdata);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_recv_error();
        test_rx_during_resp();
        test_reset_mid();
        test_back_to_back();
        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
